// File: rtl/redmule_tile_evt_unit_pkg.sv
// Shared types and default parameters for the RedMulE tile event unit.
package redmule_tile_evt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAKE,
    WAIT_RUN
  } wake_state_e;

  localparam int unsigned DEF_N_EVT   = 2;
  localparam int unsigned DEF_CNT_W   = 4;
  localparam int unsigned DEF_IRQ_ID  = 11;
  localparam int unsigned DEF_TIMEOUT = 1024;

endpackage

// File: rtl/redmule_tile_evt_unit_if.sv
// Tile-facing link of the event unit: event/busy/sleep in, irq/wake-up out.
interface redmule_tile_evt_unit_if #(
  parameter int unsigned N_EVT = redmule_tile_evt_pkg::DEF_N_EVT
);
  logic [N_EVT-1:0] evt_i;
  logic             busy_i;
  logic             core_sleep_i;
  logic [31:0]      irq_o;
  logic             wu_wfe_o;

  modport master (output evt_i, busy_i, core_sleep_i, input irq_o, wu_wfe_o);
  modport slave  (input evt_i, busy_i, core_sleep_i, output irq_o, wu_wfe_o);
endinterface

// File: rtl/redmule_tile_evt_unit_cnt.sv
// One saturating up/down pending counter with a registered nonzero flag.
module redmule_tile_evt_cnt #(
  parameter int unsigned CNT_W = redmule_tile_evt_pkg::DEF_CNT_W
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic pending_o,
  output logic ovf_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == CNT_MAX) ovf_o = 1'b1;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= (cnt_d != '0);
    end
  end

  assign pending_o = pending_q;
endmodule

// File: rtl/redmule_tile_evt_unit.sv
// Tile event unit: per-event pending counters, irq line and one-shot core wake-up.
// Optional busy watchdog enabled by defining REDMULE_TILE_EVT_UNIT_WDOG_EN.
module redmule_tile_evt_unit
  import redmule_tile_evt_pkg::*;
#(
  parameter int unsigned N_EVT   = DEF_N_EVT,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned IRQ_ID  = DEF_IRQ_ID,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  redmule_tile_evt_unit_if.slave tile_if,
  input  logic [N_EVT-1:0]       evt_mask_i,
  input  logic [N_EVT-1:0]       evt_ack_i,
  output logic [N_EVT-1:0]       pending_o,
  output logic                   overflow_o,
  output logic                   timeout_o
);
  logic [N_EVT-1:0] ovf_hit;
  logic             overflow_q;
  logic             irq_line;
  wake_state_e      state_q, state_d;

  for (genvar g = 0; g < N_EVT; g++) begin : g_cnt
    redmule_tile_evt_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .inc_i     (tile_if.evt_i[g]),
      .dec_i     (evt_ack_i[g]),
      .pending_o (pending_o[g]),
      .ovf_o     (ovf_hit[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) overflow_q <= 1'b0;
    else         overflow_q <= overflow_q | (|ovf_hit);
  end
  assign overflow_o = overflow_q;

`ifdef REDMULE_TILE_EVT_UNIT_WDOG_EN
  localparam int unsigned         WDOG_W     = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0]   WDOG_LIMIT = WDOG_W'(TIMEOUT);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_q;

  // Counter parks at the limit so a long busy phase cannot wrap around.
  always_comb begin
    wdog_d = '0;
    if (tile_if.busy_i) wdog_d = (wdog_q == WDOG_LIMIT) ? wdog_q : wdog_q + WDOG_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_q | (wdog_d == WDOG_LIMIT);
    end
  end
  assign timeout_o = timeout_q;
`else
  logic wdog_unused;
  assign wdog_unused = tile_if.busy_i ^ (TIMEOUT == 0);
  assign timeout_o   = 1'b0;
`endif

  // Mask is applied combinationally so unmasking a pending event raises irq at once.
  assign irq_line = (|(pending_o & evt_mask_i)) | timeout_o;

  always_comb begin
    tile_if.irq_o         = '0;
    tile_if.irq_o[IRQ_ID] = irq_line;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    tile_if.wu_wfe_o = 1'b0;
    unique case (state_q)
      IDLE:     if (tile_if.core_sleep_i && irq_line) state_d = WAKE;
      WAKE: begin
        tile_if.wu_wfe_o = 1'b1;
        state_d          = WAIT_RUN;
      end
      WAIT_RUN: if (!tile_if.core_sleep_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_redmule_tile_evt_unit.sv
// Scoreboard bench for redmule_tile_evt_unit against a behavioural event/wake model.
module tb_redmule_tile_evt_unit;
  localparam int N_EVT   = 2;
  localparam int CNT_W   = 4;
  localparam int IRQ_ID  = 11;
  localparam int TIMEOUT = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef REDMULE_TILE_EVT_UNIT_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic [N_EVT-1:0] evt_mask_i, evt_ack_i, pending_o;
  logic             overflow_o, timeout_o;

  redmule_tile_evt_unit_if #(.N_EVT(N_EVT)) tile_if ();

  redmule_tile_evt_unit #(
    .N_EVT(N_EVT), .CNT_W(CNT_W), .IRQ_ID(IRQ_ID), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .tile_if    (tile_if.slave),
    .evt_mask_i (evt_mask_i),
    .evt_ack_i  (evt_ack_i),
    .pending_o  (pending_o),
    .overflow_o (overflow_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [N_EVT-1:0] pending;
    logic [31:0]      irq;
    logic             wu;
    logic             ovf;
    logic             tmo;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state: event counts, sticky flags, busy run length and wake bookkeeping.
  int               m_cnt[N_EVT];
  logic [N_EVT-1:0] m_pending;
  bit               m_ovf, m_tmo, m_wu, m_woken;
  int               m_busy_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [N_EVT-1:0] evt, input logic [N_EVT-1:0] ack,
                      input logic [N_EVT-1:0] mask, input logic busy,
                      input logic sleep, input logic rst_n);
    exp_t e;
    bit   irq_before, wu_next;
    @(negedge clk_i);
    tile_if.evt_i        = evt;
    evt_ack_i            = ack;
    evt_mask_i           = mask;
    tile_if.busy_i       = busy;
    tile_if.core_sleep_i = sleep;
    rstn_i               = rst_n;

    irq_before = (|(m_pending & mask)) || m_tmo;
    if (!rst_n) begin
      for (int i = 0; i < N_EVT; i++) m_cnt[i] = 0;
      m_pending = '0; m_ovf = 0; m_tmo = 0; m_wu = 0; m_woken = 0; m_busy_run = 0;
    end else begin
      for (int i = 0; i < N_EVT; i++) begin
        if (evt[i] && !ack[i]) begin
          if (m_cnt[i] == CNT_MAX) m_ovf = 1;
          else                     m_cnt[i]++;
        end else if (ack[i] && !evt[i] && m_cnt[i] > 0) begin
          m_cnt[i]--;
        end
        m_pending[i] = (m_cnt[i] != 0);
      end
      if (busy) m_busy_run = (m_busy_run < TIMEOUT) ? m_busy_run + 1 : m_busy_run;
      else      m_busy_run = 0;
      if (WDOG_EN && m_busy_run == TIMEOUT) m_tmo = 1;
      // One pulse per sleep episode; the core must be seen awake before the next one.
      wu_next = !m_wu && !m_woken && sleep && irq_before;
      m_woken = m_wu || (m_woken && sleep);
      m_wu    = wu_next;
    end

    e.pending     = m_pending;
    e.irq         = '0;
    e.irq[IRQ_ID] = (|(m_pending & mask)) || m_tmo;
    e.wu          = m_wu;
    e.ovf         = m_ovf;
    e.tmo         = m_tmo;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pending_o",  32'(pending_o),        32'(e.pending));
        check("irq_o",      tile_if.irq_o,         e.irq);
        check("wu_wfe_o",   32'(tile_if.wu_wfe_o), 32'(e.wu));
        check("overflow_o", 32'(overflow_o),       32'(e.ovf));
        check("timeout_o",  32'(timeout_o),        32'(e.tmo));
      end
    end
  end

  initial begin : stimulus
    logic             sleep_r;
    logic [N_EVT-1:0] mask_r;
    int               waited;
    tile_if.evt_i = '0; tile_if.busy_i = 0; tile_if.core_sleep_i = 0;
    evt_mask_i = '0; evt_ack_i = '0; rstn_i = 0;
    for (int i = 0; i < N_EVT; i++) m_cnt[i] = 0;
    m_pending = '0; m_ovf = 0; m_tmo = 0; m_wu = 0; m_woken = 0; m_busy_run = 0;

    repeat (2) step('0, '0, '0, 0, 0, 0);

    // Single event, awake core, then acknowledge.
    step(2'b01, 2'b00, 2'b01, 0, 0, 1);
    step(2'b00, 2'b00, 2'b01, 0, 0, 1);
    step(2'b00, 2'b01, 2'b01, 0, 0, 1);
    step(2'b00, 2'b00, 2'b01, 0, 0, 1);

    // Sleeping core: one wake-up pulse only, then core wakes and acks.
    step(2'b10, 2'b00, 2'b10, 0, 1, 1);
    repeat (7) step(2'b00, 2'b00, 2'b10, 0, 1, 1);
    step(2'b00, 2'b00, 2'b10, 0, 0, 1);
    step(2'b00, 2'b10, 2'b10, 0, 0, 1);
    step(2'b00, 2'b00, 2'b10, 0, 0, 1);

    // Masked pending event: no irq, then unmask raises irq in the same cycle.
    step(2'b01, 2'b00, 2'b00, 0, 1, 1);
    repeat (2) step(2'b00, 2'b00, 2'b00, 0, 1, 1);
    step(2'b00, 2'b00, 2'b01, 0, 0, 1);
    step(2'b00, 2'b01, 2'b01, 0, 0, 1);

    // Saturation and overflow, then drain with acks.
    repeat (16) step(2'b01, 2'b00, 2'b00, 0, 0, 1);
    repeat (15) step(2'b00, 2'b01, 2'b00, 0, 0, 1);
    step(2'b00, 2'b00, 2'b00, 0, 0, 1);

    // Simultaneous event and ack at count 3.
    repeat (3) step(2'b01, 2'b00, 2'b01, 0, 0, 1);
    step(2'b01, 2'b01, 2'b01, 0, 0, 1);
    repeat (3) step(2'b00, 2'b01, 2'b01, 0, 0, 1);

    // Busy watchdog: 18 busy cycles, then idle.
    repeat (18) step(2'b00, 2'b00, 2'b00, 1, 0, 1);
    repeat (2) step(2'b00, 2'b00, 2'b00, 0, 0, 1);

    // Reset while the wake FSM is in WAKE, and reset on the edge that would enter WAKE.
    step('0, '0, '0, 0, 0, 0);
    step(2'b01, 2'b00, 2'b01, 0, 1, 1);
    step(2'b00, 2'b00, 2'b01, 0, 1, 1);
    step(2'b00, 2'b00, 2'b01, 0, 1, 0);
    repeat (2) step(2'b00, 2'b00, 2'b01, 0, 1, 1);
    step(2'b01, 2'b00, 2'b01, 0, 1, 1);
    step(2'b00, 2'b00, 2'b01, 0, 1, 0);
    repeat (2) step(2'b00, 2'b00, 2'b01, 0, 1, 1);

    // Randomized traffic with occasional resets.
    sleep_r = 0;
    mask_r  = '0;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 7) == 0) sleep_r = ~sleep_r;
      if ($urandom_range(0, 5) == 0) mask_r  = N_EVT'($urandom);
      step(N_EVT'($urandom), N_EVT'($urandom & $urandom), mask_r,
           logic'($urandom_range(0, 9) != 0), sleep_r, logic'($urandom_range(0, 99) != 0));
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(negedge clk_i);
      waited++;
    end
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
